// File: rtl/ff_fifo_pow2_depth_core_pkg.sv
// ----------------------------------------------------------------------------
// ff_fifo_pkg
// Shared helpers for the flip-flop FIFO slice.
//   is_pow2(value)    : 1 when value is a positive power of two.
//   ptr_width(depth)  : pointer width for a FIFO of the given depth; it carries
//                       one extra wrap bit beyond the storage index.
// Nothing here depends on the data width, which stays a module parameter.
// ----------------------------------------------------------------------------
package ff_fifo_pkg;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ff_fifo_pow2_depth_core_if.sv
// ----------------------------------------------------------------------------
// ff_fifo_pow2_depth_core_if
// Producer/consumer handshake bundle for ff_fifo_pow2_depth_core.
//   push        : write request (producer -> FIFO)
//   pop         : read request (consumer -> FIFO)
//   write_data  : word written on an accepted push
//   read_data   : show-ahead head word, meaningful while empty = 0
//   empty/full  : occupancy flags
// Modports: master = producer/consumer side, slave = FIFO side.
// ----------------------------------------------------------------------------
interface ff_fifo_pow2_depth_core_if #(
    parameter int width = 8
);
    logic             push;
    logic             pop;
    logic [width-1:0] write_data;
    logic [width-1:0] read_data;
    logic             empty;
    logic             full;

    modport master (
        output push, pop, write_data,
        input  read_data, empty, full
    );

    modport slave (
        input  push, pop, write_data,
        output read_data, empty, full
    );
endinterface

// File: rtl/ff_fifo_pow2_depth_core_ptr.sv
// ----------------------------------------------------------------------------
// ff_fifo_ptr
// Registered FIFO pointer that wraps naturally modulo 2**ptr_w.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, clears the pointer to zero
//   inc  : advance the pointer by one at the next clock edge
//   ptr  : full pointer value (storage index in low bits, wrap bit in MSB)
// ----------------------------------------------------------------------------
module ff_fifo_ptr
    import ff_fifo_pkg::*;
#(
    parameter int ptr_w = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [ptr_w-1:0] ptr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ptr_w'(1);
        end
    end

endmodule

// File: rtl/ff_fifo_pow2_depth_core.sv
// ----------------------------------------------------------------------------
// ff_fifo_pow2_depth_core
// Single-clock FIFO with flip-flop storage and power-of-two depth.
// Show-ahead read: read_data is a combinational view of the head entry.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset (empties the FIFO, storage untouched)
//   bus  : slave side of ff_fifo_pow2_depth_core_if
//          (push, pop, write_data in; read_data, empty, full out)
// Parameters: width (data bits, >=1), depth (entries, power of two, >=2).
// Optional macro FF_FIFO_POW2_DEPTH_CORE_CHECKS_EN adds simulation-only
// overflow/underflow/flag-consistency/depth assertions.
// ----------------------------------------------------------------------------
module ff_fifo_pow2_depth_core
    import ff_fifo_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    ff_fifo_pow2_depth_core_if.slave   bus
);

    localparam int pw = ptr_width(depth);
    localparam int aw = pw - 1;

    if (!is_pow2(depth) || depth < 2) begin : g_bad_depth
        $error("ff_fifo_pow2_depth_core: depth %0d must be a power of two >= 2", depth);
    end
    if (width < 1) begin : g_bad_width
        $error("ff_fifo_pow2_depth_core: width %0d must be >= 1", width);
    end

    logic [pw-1:0]    wr_ptr;
    logic [pw-1:0]    rd_ptr;
    logic             empty_int;
    logic             full_int;
    logic             push_ok;
    logic             pop_ok;
    logic [width-1:0] mem [depth];

    // Flags decode only the registered pointers, so storage X never reaches them.
    assign empty_int = (wr_ptr == rd_ptr);
    assign full_int  = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);

    // A pop while full frees the slot the write lands in; a pop while empty
    // is ignored, so there is no empty bypass.
    assign pop_ok  = bus.pop && !empty_int;
    assign push_ok = bus.push && (!full_int || bus.pop);

    ff_fifo_ptr #(.ptr_w(pw)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_ok),
        .ptr (wr_ptr)
    );

    ff_fifo_ptr #(.ptr_w(pw)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_ok),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[aw-1:0]] <= bus.write_data;
        end
    end

    assign bus.read_data = mem[rd_ptr[aw-1:0]];
    assign bus.empty     = empty_int;
    assign bus.full      = full_int;

`ifdef FF_FIFO_POW2_DEPTH_CORE_CHECKS_EN
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(bus.push && full_int && !bus.pop))
        else $error("ff_fifo overflow: wr_ptr=%0d rd_ptr=%0d", wr_ptr, rd_ptr);

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(bus.pop && empty_int))
        else $error("ff_fifo underflow: wr_ptr=%0d rd_ptr=%0d", wr_ptr, rd_ptr);

    a_flags_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(empty_int && full_int))
        else $error("ff_fifo empty and full together: wr_ptr=%0d rd_ptr=%0d", wr_ptr, rd_ptr);

    a_depth_pow2: assert property (@(posedge clk) disable iff (!rst)
        is_pow2(depth))
        else $error("ff_fifo depth not a power of two: wr_ptr=%0d rd_ptr=%0d", wr_ptr, rd_ptr);
`else
    // Checks not compiled in this build.
`endif

endmodule

// File: tb/tb_ff_fifo_pow2_depth_core.sv
// ----------------------------------------------------------------------------
// tb_ff_fifo_pow2_depth_core
// Scoreboard bench for ff_fifo_pow2_depth_core (width 8, depth 8).
// The stimulus process keeps a reference queue of FIFO contents, and for every
// cycle pushes the expected flags and, on each accepted pop, the expected head
// word into scoreboard queues. A monitor samples on the falling edge and
// compares whatever the DUT presents against those queues.
// ----------------------------------------------------------------------------
module tb_ff_fifo_pow2_depth_core;

    localparam int W = 8;
    localparam int D = 8;

    logic clk;
    logic rst;

    ff_fifo_pow2_depth_core_if #(.width(W)) bus ();

    ff_fifo_pow2_depth_core #(.width(W), .depth(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] model_q [$];  // FIFO contents as seen right after the last edge
    logic [W-1:0] exp_data [$]; // expected head word for each accepted pop
    logic [1:0]   exp_flags [$]; // expected {empty, full} for each cycle

    // Monitor: falling edge, halfway between input changes and the active edge.
    always @(negedge clk) begin
        if (exp_flags.size() != 0) begin
            logic [1:0] ef;
            ef = exp_flags.pop_front();
            checks++;
            if ({bus.empty, bus.full} !== ef) begin
                errors++;
                $display("FAIL flags t=%0t: got empty=%b full=%b, expected empty=%b full=%b",
                         $time, bus.empty, bus.full, ef[1], ef[0]);
            end
        end
        if (rst === 1'b1 && bus.pop === 1'b1 && bus.empty === 1'b0) begin
            checks++;
            if (exp_data.size() == 0) begin
                errors++;
                $display("FAIL read_data t=%0t: unexpected pop accepted, read_data=%h, no word expected",
                         $time, bus.read_data);
            end else begin
                logic [W-1:0] ed;
                ed = exp_data.pop_front();
                if (bus.read_data !== ed) begin
                    errors++;
                    $display("FAIL read_data t=%0t: got %h, expected %h", $time, bus.read_data, ed);
                end
            end
        end
    end

    // One cycle of stimulus; inputs change 1 time unit after the rising edge.
    task automatic step(input logic p, input logic r, input logic [W-1:0] d);
        logic pop_acc;
        logic push_acc;
        bus.push       = p;
        bus.pop        = r;
        bus.write_data = d;
        exp_flags.push_back({model_q.size() == 0, model_q.size() == D});
        pop_acc  = r && (model_q.size() != 0);
        push_acc = p && ((model_q.size() != D) || r);
        if (pop_acc) begin
            exp_data.push_back(model_q[0]);
            void'(model_q.pop_front());
        end
        if (push_acc) model_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; flags are expected at the next
    // falling edge, before any clock edge has occurred.
    task automatic reset_cycles(input int unsigned n);
        rst            = 1'b0;
        bus.push       = 1'b0;
        bus.pop        = 1'b0;
        bus.write_data = '0;
        model_q.delete();
        for (int unsigned i = 0; i < n; i++) begin
            exp_flags.push_back(2'b10);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
    endtask

    initial begin
        rst            = 1'b0;
        bus.push       = 1'b0;
        bus.pop        = 1'b0;
        bus.write_data = '0;
        @(posedge clk);
        #1;

        // Reset held 3 cycles, then 2 idle cycles.
        reset_cycles(3);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);

        // Fill with 0x00..0x77, then drain in order.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, W'(i * 8'h11));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Half full, then 40 cycles of push+pop across pointer wrap.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, W'(i * 8'h11));
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, W'((i % 8) * 8'h11));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Full with push+pop: 0xA5 is the 8th word out afterwards.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, W'(8'h80 + i));
        step(1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Illegal: push while full (ignored), pop while empty (ignored).
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, W'(8'hC0 + i));
        step(1'b1, 1'b0, 8'hEE);
        step(1'b1, 1'b0, 8'hEF);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Random traffic with a reset in the middle.
        for (int i = 0; i < 100; i++) begin
            logic p;
            logic r;
            if (i == 50) reset_cycles(2);
            if (model_q.size() == D) begin
                p = ($urandom_range(0, 99) < 40);
                r = p;
            end else begin
                p = ($urandom_range(0, 99) < 60);
                r = (model_q.size() != 0) && ($urandom_range(0, 99) < 50);
            end
            step(p, r, W'($urandom));
        end
        while (model_q.size() != 0) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_data.size() != 0 || exp_flags.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d words and %0d flag entries left unchecked, expected 0 and 0",
                     exp_data.size(), exp_flags.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
